// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers: per-boundary slice widths,
// skid-buffer state encoding and DE control-slice field offsets.
package pipe_pkg;

  localparam int DE_CTRL_WIDTH = 12;
  localparam int DE_DATA_WIDTH = 148;
  localparam int EM_CTRL_WIDTH = 8;
  localparam int EM_DATA_WIDTH = 104;
  localparam int MW_CTRL_WIDTH = 4;
  localparam int MW_DATA_WIDTH = 69;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = EMPTY,
    ST_ONE   = ONE,
    ST_TWO   = TWO
  } skid_state_e;

  // DE control slice layout; an all-zero slice decodes as a NOP.
  localparam int DE_REG_WRITE_BIT  = 0;
  localparam int DE_MEM_READ_BIT   = 1;
  localparam int DE_MEM_WRITE_BIT  = 2;
  localparam int DE_MEM_TO_REG_BIT = 3;
  localparam int DE_ALU_SRC_BIT    = 4;
  localparam int DE_BRANCH_BIT     = 5;
  localparam int DE_JUMP_BIT       = 6;
  localparam int DE_ALU_OP_LSB     = 7;
  localparam int DE_ALU_OP_WIDTH   = 4;
  localparam int DE_JALR_BIT       = 11;

  function automatic logic [DE_ALU_OP_WIDTH-1:0] de_alu_op(input logic [DE_CTRL_WIDTH-1:0] ctrl);
    return ctrl[DE_ALU_OP_LSB +: DE_ALU_OP_WIDTH];
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry head/skid storage with a registered in_ready; empty entries are
// held at zero so the head register always reads as a bubble when invalid.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = 160
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_payload_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_payload_o
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             valid_q;
  logic             in_ready_q;
  logic             in_xfer_s;
  logic             out_xfer_s;

  assign in_xfer_s  = in_valid_i & in_ready_q;
  assign out_xfer_s = valid_q & out_ready_i;

  // Next-state and storage update; flush empties both entries.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      head_d  = {WIDTH{1'b0}};
      skid_d  = {WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            state_d = ST_ONE;
            head_d  = in_payload_i;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            head_d = in_payload_i;
          end else if (in_xfer_s) begin
            state_d = ST_TWO;
            skid_d  = in_payload_i;
          end else if (out_xfer_s) begin
            state_d = ST_EMPTY;
            head_d  = {WIDTH{1'b0}};
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_xfer_s) begin
            state_d = ST_ONE;
            head_d  = skid_q;
            skid_d  = {WIDTH{1'b0}};
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          head_d  = {WIDTH{1'b0}};
          skid_d  = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // in_ready and out_valid are registered from next state, cutting any out_ready path.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      head_q     <= {WIDTH{1'b0}};
      skid_q     <= {WIDTH{1'b0}};
      valid_q    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      valid_q    <= (state_d != ST_EMPTY);
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = valid_q;
  assign out_payload_o = head_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register with optional skid buffer, flush-to-bubble
// and a saturating back-pressure counter.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int CTRL_WIDTH = DE_CTRL_WIDTH,
  parameter int DATA_WIDTH = DE_DATA_WIDTH,
  parameter int SKID       = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam int W = CTRL_WIDTH + DATA_WIDTH;

  logic [W-1:0]         in_payload_s;
  logic [W-1:0]         head_s;
  logic                 valid_s;
  logic                 ready_s;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign in_payload_s = {in_ctrl, in_data};

  if (SKID != 0) begin : g_skid
    pipe_skid_buf #(
      .WIDTH(W)
    ) u_buf (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (flush),
      .in_valid_i   (in_valid),
      .in_ready_o   (ready_s),
      .in_payload_i (in_payload_s),
      .out_valid_o  (valid_s),
      .out_ready_i  (out_ready),
      .out_payload_o(head_s)
    );
  end else begin : g_single
    logic [W-1:0] head_q, head_d;
    logic         valid_q, valid_d;

    assign ready_s = ~valid_q | out_ready;

    // Single head register: load on accept, drop to bubble when drained or flushed.
    always_comb begin
      head_d  = head_q;
      valid_d = valid_q;
      if (flush) begin
        head_d  = {W{1'b0}};
        valid_d = 1'b0;
      end else if (in_valid && ready_s) begin
        head_d  = in_payload_s;
        valid_d = 1'b1;
      end else if (valid_q && out_ready) begin
        head_d  = {W{1'b0}};
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end

    // Head storage register.
    always_ff @(posedge clk) begin
      if (rst) begin
        head_q  <= {W{1'b0}};
        valid_q <= 1'b0;
      end else begin
        head_q  <= head_d;
        valid_q <= valid_d;
      end
    end

    assign head_s  = head_q;
    assign valid_s = valid_q;
  end

  // Saturating stall counter; flush leaves it alone, only rst clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_s && !out_ready && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = valid_s;
  assign out_ctrl  = head_s[W-1:DATA_WIDTH];
  assign out_data  = head_s[DATA_WIDTH-1:0];
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: skid mode, single-register mode and a
// narrow-counter instance for saturation.
module tb_pipe_stage_hs;

  logic clk = 1'b0;
  logic rst;

  logic         flush, iv, ordy, irdy, ov;
  logic [11:0]  ictrl, octrl;
  logic [147:0] idata, odata;
  logic [15:0]  scnt;

  logic         flush0, iv0, ordy0, irdy0, ov0;
  logic [11:0]  ictrl0, octrl0;
  logic [147:0] idata0, odata0;
  logic [15:0]  scnt0;

  logic         flushs, ivs, ordys, irdys, ovs;
  logic [11:0]  ictrls, octrls;
  logic [147:0] idatas, odatas;
  logic [3:0]   scnts;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_hs #(.CTRL_WIDTH(12), .DATA_WIDTH(148), .SKID(1), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv), .in_ready(irdy),
    .in_ctrl(ictrl), .in_data(idata), .out_valid(ov), .out_ready(ordy),
    .out_ctrl(octrl), .out_data(odata), .stall_cnt(scnt));

  pipe_stage_hs #(.CTRL_WIDTH(12), .DATA_WIDTH(148), .SKID(0), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .in_valid(iv0), .in_ready(irdy0),
    .in_ctrl(ictrl0), .in_data(idata0), .out_valid(ov0), .out_ready(ordy0),
    .out_ctrl(octrl0), .out_data(odata0), .stall_cnt(scnt0));

  pipe_stage_hs #(.CTRL_WIDTH(12), .DATA_WIDTH(148), .SKID(1), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flushs), .in_valid(ivs), .in_ready(irdys),
    .in_ctrl(ictrls), .in_data(idatas), .out_valid(ovs), .out_ready(ordys),
    .out_ctrl(octrls), .out_data(odatas), .stall_cnt(scnts));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic       exp_rdy0 [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] exp_dat0 [6] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};

  initial begin
    int beat;
    rst = 1'b1; flush = 1'b0; iv = 1'b1; ictrl = 12'hFFF; idata = 148'h5; ordy = 1'b1;
    flush0 = 1'b0; iv0 = 1'b0; ictrl0 = 12'h0; idata0 = 148'h0; ordy0 = 1'b0;
    flushs = 1'b0; ivs = 1'b0; ictrls = 12'h0; idatas = 148'h0; ordys = 1'b0;

    // reset held two cycles while upstream offers a beat
    tick(); tick();
    chk("rst_ov",   160'(ov),    160'(0));
    chk("rst_ctrl", 160'(octrl), 160'(0));
    chk("rst_data", 160'(odata), 160'(0));
    chk("rst_cnt",  160'(scnt),  160'(0));
    chk("rst_rdy",  160'(irdy),  160'(1));
    chk("rst_rdy0", 160'(irdy0), 160'(1));
    rst = 1'b0; iv = 1'b0; ictrl = 12'h0; idata = 148'h0;
    tick();
    chk("post_rst_ov", 160'(ov), 160'(0));

    // streaming with out_ready high
    ordy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      iv = 1'b1; idata = 148'(i); ictrl = 12'(i + 16);
      tick();
      chk("stream_ov",   160'(ov),    160'(1));
      chk("stream_data", 160'(odata), 160'(i));
      chk("stream_ctrl", 160'(octrl), 160'(i + 16));
      chk("stream_rdy",  160'(irdy),  160'(1));
    end
    iv = 1'b0; idata = 148'h0; ictrl = 12'h0;
    tick();
    chk("stream_end_ov",   160'(ov),    160'(0));
    chk("stream_end_data", 160'(odata), 160'(0));

    // back-pressure: A and B accepted, C held upstream
    ordy = 1'b0; iv = 1'b1; idata = 148'hA; ictrl = 12'h0A;
    tick();
    chk("bp_a_data", 160'(odata), 160'hA);
    chk("bp_a_rdy",  160'(irdy),  160'(1));
    chk("bp_a_cnt",  160'(scnt),  160'(0));
    idata = 148'hB; ictrl = 12'h0B;
    tick();
    chk("bp_b_rdy",  160'(irdy),  160'(0));
    chk("bp_b_data", 160'(odata), 160'hA);
    chk("bp_b_cnt",  160'(scnt),  160'(1));
    idata = 148'hC; ictrl = 12'h0C;
    tick();
    chk("bp_c_rdy",  160'(irdy),  160'(0));
    chk("bp_c_data", 160'(odata), 160'hA);
    chk("bp_c_ctrl", 160'(octrl), 160'h0A);
    chk("bp_c_cnt",  160'(scnt),  160'(2));
    tick();
    chk("bp_c2_data", 160'(odata), 160'hA);
    chk("bp_c2_cnt",  160'(scnt),  160'(3));
    ordy = 1'b1;
    tick();
    chk("bp_rel_b",   160'(odata), 160'hB);
    chk("bp_rel_rdy", 160'(irdy),  160'(1));
    chk("bp_rel_cnt", 160'(scnt),  160'(3));
    tick();
    chk("bp_rel_c", 160'(odata), 160'hC);
    iv = 1'b0; idata = 148'h0; ictrl = 12'h0;
    tick();
    chk("bp_drain_ov", 160'(ov), 160'(0));

    // flush while holding two beats, with a beat offered the same cycle
    ordy = 1'b0; iv = 1'b1; idata = 148'h11; ictrl = 12'h011;
    tick();
    idata = 148'h22; ictrl = 12'h022;
    tick();
    chk("fl_two_rdy",  160'(irdy),  160'(0));
    chk("fl_two_data", 160'(odata), 160'h11);
    chk("fl_two_cnt",  160'(scnt),  160'(4));
    flush = 1'b1; idata = 148'hD; ictrl = 12'h00D;
    tick();
    chk("fl_ov",   160'(ov),    160'(0));
    chk("fl_ctrl", 160'(octrl), 160'(0));
    chk("fl_data", 160'(odata), 160'(0));
    chk("fl_rdy",  160'(irdy),  160'(1));
    chk("fl_cnt",  160'(scnt),  160'(5));
    flush = 1'b0; iv = 1'b0; ordy = 1'b1;
    tick();
    chk("fl_no_d_ov",   160'(ov),    160'(0));
    chk("fl_no_d_data", 160'(odata), 160'(0));
    flush = 1'b1; iv = 1'b1; idata = 148'hE; ictrl = 12'h00E;
    tick();
    chk("fl_empty_ov",  160'(ov),   160'(0));
    chk("fl_empty_cnt", 160'(scnt), 160'(5));
    flush = 1'b0; iv = 1'b0;
    tick();
    chk("fl_empty2_ov", 160'(ov), 160'(0));

    // single-register mode: out_ready toggling under a continuous stream
    beat = 1;
    iv0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ordy0 = (k % 2 == 0);
      idata0 = 148'(beat); ictrl0 = 12'(beat);
      #1;
      chk("s0_rdy", 160'(irdy0), 160'(exp_rdy0[k]));
      if (irdy0) beat++;
      tick();
      chk("s0_ov",   160'(ov0),    160'(1));
      chk("s0_data", 160'(odata0), 160'(exp_dat0[k]));
      chk("s0_ctrl", 160'(octrl0), 160'(exp_dat0[k]));
    end
    chk("s0_cnt", 160'(scnt0), 160'(3));
    iv0 = 1'b0; ordy0 = 1'b1;
    #1;
    chk("s0_drain_rdy", 160'(irdy0), 160'(1));
    tick();
    chk("s0_drain_ov",   160'(ov0),    160'(0));
    chk("s0_drain_data", 160'(odata0), 160'(0));

    // saturation on the 4-bit counter instance
    ivs = 1'b1; idatas = 148'h7; ictrls = 12'h003; ordys = 1'b0;
    tick();
    ivs = 1'b0;
    chk("sat_ov",   160'(ovs),    160'(1));
    chk("sat_data", 160'(odatas), 160'h7);
    chk("sat_ctrl", 160'(octrls), 160'h3);
    chk("sat_rdy",  160'(irdys),  160'(1));
    chk("sat_cnt0", 160'(scnts),  160'(0));
    repeat (14) tick();
    chk("sat_cnt14", 160'(scnts), 160'(14));
    repeat (6) tick();
    chk("sat_cnt20", 160'(scnts), 160'(15));
    tick();
    chk("sat_hold", 160'(scnts), 160'(15));
    chk("sat_data_stable", 160'(odatas), 160'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sat_rst_cnt",  160'(scnts), 160'(0));
    chk("sat_rst_ov",   160'(ovs),   160'(0));
    chk("main_rst_cnt", 160'(scnt),  160'(0));
    chk("s0_rst_cnt",   160'(scnt0), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
